// File: rtl/rd_burst_fsm.sv
// rd_burst_fsm: multi-beat read sequencer for a slow peripheral.
// A go pulse in IDLE launches len+1 read beats. Each beat is one READ cycle
// followed by wait_cyc+1 DLY cycles. A ws request on the last DLY cycle
// re-reads the same beat.
// Optional feature: define RD_BURST_WS_TIMEOUT_EN to bound consecutive
// retries per beat at MAX_RETRY. When the bound is hit, the burst ends in
// DONE with err set. Without the macro, retries are unlimited and err is 0.
// All control outputs come straight from flops. rd, rd_strb, ds and busy are
// bits of the state encoding.

module rd_burst_fsm #(
    parameter int BEATS_W   = 4,
    parameter int WAIT_W    = 4,
    parameter int MAX_RETRY = 7
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               go,
    input  logic [BEATS_W-1:0] len,
    input  logic [WAIT_W-1:0]  wait_cyc,
    input  logic               ws,
    output logic               rd,
    output logic               rd_strb,
    output logic               ds,
    output logic               err,
    output logic               busy,
    output logic [BEATS_W-1:0] beat_cnt
);

    // State encoding carries the outputs: [3]=busy [2]=ds [1]=rd_strb [0]=rd.
    // Every state has a distinct output pattern, so no extra id bits are needed.
    localparam logic [3:0] IDLE = 4'b0000;
    localparam logic [3:0] READ = 4'b1011;
    localparam logic [3:0] DLY  = 4'b1001;
    localparam logic [3:0] DONE = 4'b1100;

    // Retry bound must fit the 8-bit retry counter.
    if (MAX_RETRY < 1 || MAX_RETRY > 255) begin : g_bad_max_retry
        $error("rd_burst_fsm: MAX_RETRY must be in 1..255");
    end

    logic [3:0]         state;
    logic [3:0]         state_nxt;
    logic [BEATS_W-1:0] len_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  dly_cnt;
    logic               accept;
    logic               last_dly;
    logic               last_beat;
    logic               abort_now;

    assign accept    = (state == IDLE) && go;
    assign last_dly  = (state == DLY) && (dly_cnt == '0);
    assign last_beat = (beat_cnt == len_q);

`ifdef RD_BURST_WS_TIMEOUT_EN
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    logic [7:0] retry_cnt;

    // A ws at the retry limit on the last DLY cycle aborts the burst.
    assign abort_now = last_dly && ws && (retry_cnt == RETRY_LIM);

    // Consecutive-retry counter for the current beat; saturates at the limit.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            retry_cnt <= '0;
        end else if (accept) begin
            retry_cnt <= '0;
        end else if (last_dly) begin
            if (ws) begin
                if (retry_cnt != RETRY_LIM) begin
                    retry_cnt <= retry_cnt + 8'd1;
                end
            end else begin
                retry_cnt <= '0;
            end
        end
    end

    // err flags the DONE cycle that results from a retry-limit abort.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            err <= 1'b0;
        end else begin
            err <= abort_now;
        end
    end
`else
    // Unlimited retries: there is no abort path and err never asserts.
    assign abort_now = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state selection for the four-state sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = DLY;
            end
            DLY: begin
                if (dly_cnt == '0) begin
                    if (ws) begin
                        state_nxt = abort_now ? DONE : READ;
                    end else if (last_beat) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset lands in IDLE so every output reads 0.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst parameters are latched only when a burst is accepted, and the
    // per-beat delay counter is reloaded on every READ. None of these need
    // reset because they are only consulted after being loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q  <= len;
            wait_q <= wait_cyc;
        end
        if (state == READ) begin
            dly_cnt <= wait_q;
        end else if (state == DLY && dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Beat index: cleared on accept, advanced when a beat completes with
    // more beats to go, held through retries and through DONE.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (last_dly && !ws && !last_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign busy    = state[3];
    assign ds      = state[2];
    assign rd_strb = state[1];
    assign rd      = state[0];

endmodule

// File: tb/tb_rd_burst_fsm.sv
// Directed bench for rd_burst_fsm. Each step drives go/ws, advances one clock,
// and checks {rd, rd_strb, ds, busy, err, beat_cnt} against a hand-derived
// value for the cycle that follows that edge.

module tb_rd_burst_fsm;

    logic       clk = 1'b0;
    logic       resetb;
    logic       go;
    logic [3:0] len;
    logic [3:0] wait_cyc;
    logic       ws;
    logic       rd;
    logic       rd_strb;
    logic       ds;
    logic       err;
    logic       busy;
    logic [3:0] beat_cnt;

    int total  = 0;
    int passed = 0;

    rd_burst_fsm #(
        .BEATS_W  (4),
        .WAIT_W   (4),
        .MAX_RETRY(2)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .go       (go),
        .len      (len),
        .wait_cyc (wait_cyc),
        .ws       (ws),
        .rd       (rd),
        .rd_strb  (rd_strb),
        .ds       (ds),
        .err      (err),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    // Expected vectors, bit order {rd, rd_strb, ds, busy, err, beat_cnt}.
    function automatic logic [8:0] idv(input logic [3:0] b);
        return {5'b00000, b};
    endfunction
    function automatic logic [8:0] rdv(input logic [3:0] b);
        return {5'b11010, b};
    endfunction
    function automatic logic [8:0] dlv(input logic [3:0] b);
        return {5'b10010, b};
    endfunction
    function automatic logic [8:0] dnv(input logic [3:0] b, input logic e);
        return {4'b0011, e, b};
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = {rd, rd_strb, ds, busy, err, beat_cnt};
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b required %b (rd,strb,ds,busy,err,beat)",
                   tag, got, exp);
        end
    endtask

    task automatic step(input logic g, input logic w, input string tag,
                        input logic [8:0] exp);
        go = g;
        ws = w;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    initial begin
        resetb   = 1'b0;
        go       = 1'b0;
        ws       = 1'b0;
        len      = 4'd0;
        wait_cyc = 4'd0;
        #22;
        chk("reset", idv(4'd0));
        resetb = 1'b1;
        step(1'b0, 1'b0, "idle0", idv(4'd0));

        // Minimum burst: READ, DLY, DONE.
        len = 4'd0; wait_cyc = 4'd0;
        step(1'b1, 1'b0, "t1 read", rdv(4'd0));
        step(1'b0, 1'b0, "t1 dly",  dlv(4'd0));
        step(1'b0, 1'b0, "t1 done", dnv(4'd0, 1'b0));
        step(1'b0, 1'b0, "t1 idle", idv(4'd0));

        // len=2, wait=1: three 3-cycle beats, ds on cycle 10.
        len = 4'd2; wait_cyc = 4'd1;
        step(1'b1, 1'b0, "t2 c1", rdv(4'd0));
        for (int c = 2; c <= 9; c++) begin
            step(1'b0, 1'b0, $sformatf("t2 c%0d", c),
                 ((c - 1) % 3 == 0) ? rdv(4'((c - 1) / 3)) : dlv(4'((c - 1) / 3)));
        end
        step(1'b0, 1'b0, "t2 done", dnv(4'd2, 1'b0));
        step(1'b0, 1'b0, "t2 idle", idv(4'd2));

        // len=1, wait=2, one retry of beat 0; ws on non-last DLY cycles ignored.
        len = 4'd1; wait_cyc = 4'd2;
        step(1'b1, 1'b0, "t3 c1",  rdv(4'd0));
        step(1'b0, 1'b0, "t3 c2",  dlv(4'd0));
        step(1'b0, 1'b1, "t3 c3",  dlv(4'd0));
        step(1'b0, 1'b1, "t3 c4",  dlv(4'd0));
        step(1'b0, 1'b1, "t3 c5 retry", rdv(4'd0));
        step(1'b0, 1'b0, "t3 c6",  dlv(4'd0));
        step(1'b0, 1'b0, "t3 c7",  dlv(4'd0));
        step(1'b0, 1'b0, "t3 c8",  dlv(4'd0));
        step(1'b0, 1'b0, "t3 c9",  rdv(4'd1));
        step(1'b0, 1'b0, "t3 c10", dlv(4'd1));
        step(1'b0, 1'b1, "t3 c11", dlv(4'd1));
        step(1'b0, 1'b0, "t3 c12", dlv(4'd1));
        step(1'b0, 1'b0, "t3 done", dnv(4'd1, 1'b0));
        step(1'b0, 1'b0, "t3 idle", idv(4'd1));

        // ws held high on a single-beat burst.
        len = 4'd0; wait_cyc = 4'd0;
        step(1'b1, 1'b1, "t4 c1", rdv(4'd0));
`ifdef RD_BURST_WS_TIMEOUT_EN
        step(1'b0, 1'b1, "t4 c2", dlv(4'd0));
        step(1'b0, 1'b1, "t4 c3", rdv(4'd0));
        step(1'b0, 1'b1, "t4 c4", dlv(4'd0));
        step(1'b0, 1'b1, "t4 c5", rdv(4'd0));
        step(1'b0, 1'b1, "t4 c6", dlv(4'd0));
        step(1'b0, 1'b1, "t4 abort", dnv(4'd0, 1'b1));
        step(1'b0, 1'b0, "t4 idle", idv(4'd0));
`else
        for (int c = 2; c <= 20; c++) begin
            step(1'b0, 1'b1, $sformatf("t4 c%0d", c),
                 (c % 2 == 1) ? rdv(4'd0) : dlv(4'd0));
        end
        step(1'b0, 1'b0, "t4 release", dnv(4'd0, 1'b0));
        step(1'b0, 1'b0, "t4 idle", idv(4'd0));
`endif

        // Maximum length: 16 two-cycle beats, beat_cnt ends at 15 without wrap.
        len = 4'd15; wait_cyc = 4'd0;
        step(1'b1, 1'b0, "t7 c1", rdv(4'd0));
        for (int c = 2; c <= 32; c++) begin
            step(1'b0, 1'b0, $sformatf("t7 c%0d", c),
                 (c % 2 == 1) ? rdv(4'((c - 1) / 2)) : dlv(4'((c - 1) / 2)));
        end
        step(1'b0, 1'b0, "t7 done", dnv(4'd15, 1'b0));
        step(1'b0, 1'b0, "t7 idle", idv(4'd15));

        // Asynchronous reset during DLY of beat 1.
        len = 4'd1; wait_cyc = 4'd2;
        step(1'b1, 1'b0, "t5 c1", rdv(4'd0));
        step(1'b0, 1'b0, "t5 c2", dlv(4'd0));
        step(1'b0, 1'b0, "t5 c3", dlv(4'd0));
        step(1'b0, 1'b0, "t5 c4", dlv(4'd0));
        step(1'b0, 1'b0, "t5 c5", rdv(4'd1));
        step(1'b0, 1'b0, "t5 c6", dlv(4'd1));
        #2;
        resetb = 1'b0;
        #1;
        chk("t5 async reset", idv(4'd0));
        #2;
        resetb = 1'b1;
        step(1'b0, 1'b0, "t5 post1", idv(4'd0));
        step(1'b0, 1'b0, "t5 post2", idv(4'd0));
        step(1'b0, 1'b0, "t5 post3", idv(4'd0));

        // go held high; len/wait changed mid-burst only affect the next burst.
        len = 4'd2; wait_cyc = 4'd0;
        step(1'b1, 1'b0, "t6 c1", rdv(4'd0));
        len = 4'd5; wait_cyc = 4'd3;
        step(1'b1, 1'b0, "t6 c2", dlv(4'd0));
        step(1'b1, 1'b0, "t6 c3", rdv(4'd1));
        step(1'b1, 1'b0, "t6 c4", dlv(4'd1));
        step(1'b1, 1'b0, "t6 c5", rdv(4'd2));
        step(1'b1, 1'b0, "t6 c6", dlv(4'd2));
        step(1'b1, 1'b0, "t6 done", dnv(4'd2, 1'b0));
        step(1'b1, 1'b0, "t6 idle", idv(4'd2));
        step(1'b1, 1'b0, "t6 c9 relaunch", rdv(4'd0));
        step(1'b0, 1'b0, "t6 c10", dlv(4'd0));
        step(1'b0, 1'b0, "t6 c11", dlv(4'd0));
        step(1'b0, 1'b0, "t6 c12", dlv(4'd0));
        step(1'b0, 1'b0, "t6 c13", dlv(4'd0));
        step(1'b0, 1'b0, "t6 c14", rdv(4'd1));
        resetb = 1'b0;
        #1;
        chk("t6 reset", idv(4'd0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
